// File: rtl/mic_clk_gen.sv
// Microphone clock generator: divides clk_in down to sck/ws with edge strobes
// and sequences the mic-domain reset after PLL lock plus a run of settle frames.
module mic_clk_gen #(
  parameter int DIV_W         = 8,
  parameter int HALF_DIV_DEF  = 15,
  parameter int WS_BITS       = 64,
  parameter int SETTLE_FRAMES = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             en,
  input  logic [DIV_W-1:0] cfg_half_div,
  output logic             sck,
  output logic             ws,
  output logic             sck_rise,
  output logic             sck_fall,
  output logic             frame_start,
  output logic             rst_mic_n,
  output logic             running
);

  localparam int BW = $clog2(WS_BITS);
  localparam int FW = $clog2(SETTLE_FRAMES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WS_BITS - 1);
  localparam logic [BW-1:0] BIT_HALF = BW'(WS_BITS / 2);
  localparam logic [FW-1:0] FRM_DONE = FW'(SETTLE_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] h_q, h_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [FW-1:0]    frm_q, frm_d;
  logic             sck_q, sck_d;
  logic             ws_q, ws_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             fs_q, fs_d;
  logic             mic_q, mic_d;
  logic             run_q, run_d;

  logic             tick;
  logic             wrap;
  logic [DIV_W-1:0] h_cfg;

  // Zero half-period would never toggle; treat it as the fastest ratio.
  assign h_cfg = (cfg_half_div == '0) ? DIV_W'(1) : cfg_half_div;
  assign tick  = (div_q == h_q - DIV_W'(1));
  assign wrap  = tick && sck_q && (bit_q == BIT_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    h_d     = h_q;
    bit_d   = bit_q;
    frm_d   = frm_q;
    sck_d   = sck_q;
    ws_d    = ws_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    fs_d    = 1'b0;
    mic_d   = mic_q;
    run_d   = run_q;
    unique case (state_q)
      IDLE: begin
        div_d = '0;
        bit_d = '0;
        frm_d = '0;
        sck_d = 1'b0;
        ws_d  = 1'b0;
        mic_d = 1'b0;
        run_d = 1'b0;
        if (en && pll_lock) begin
          state_d = SETTLE;
          h_d     = h_cfg;
        end
      end
      SETTLE, RUN: begin
        if (!en || !pll_lock) begin
          state_d = IDLE;
          div_d   = '0;
          bit_d   = '0;
          frm_d   = '0;
          sck_d   = 1'b0;
          ws_d    = 1'b0;
          mic_d   = 1'b0;
          run_d   = 1'b0;
        end else begin
          if (tick) begin
            div_d  = '0;
            sck_d  = ~sck_q;
            rise_d = ~sck_q;
            fall_d = sck_q;
            if (sck_q) begin
              bit_d = wrap ? '0 : bit_q + BW'(1);
              ws_d  = (bit_d >= BIT_HALF);
            end
            if (wrap) begin
              fs_d = 1'b1;
              h_d  = h_cfg;
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
          if (state_q == SETTLE) begin
            if (frm_q == FRM_DONE) begin
              state_d = RUN;
              mic_d   = 1'b1;
              run_d   = 1'b1;
            end else if (wrap) begin
              frm_d = frm_q + FW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      h_q     <= DIV_W'(HALF_DIV_DEF);
      bit_q   <= '0;
      frm_q   <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      fs_q    <= 1'b0;
      mic_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      h_q     <= h_d;
      bit_q   <= bit_d;
      frm_q   <= frm_d;
      sck_q   <= sck_d;
      ws_q    <= ws_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      fs_q    <= fs_d;
      mic_q   <= mic_d;
      run_q   <= run_d;
    end
  end

  assign sck         = sck_q;
  assign ws          = ws_q;
  assign sck_rise    = rise_q;
  assign sck_fall    = fall_q;
  assign frame_start = fs_q;
  assign rst_mic_n   = mic_q;
  assign running     = run_q;

endmodule
